// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_pkg
//  Description : Shared encodings for the LC-3 data-memory sequencer:
//                execute-op codes and the sequencer state type.
//  Revision    : 1.0  initial release
// ============================================================================
package lc3_mem_pkg;

    // Execute-unit operation codes. Bit 1 marks the indirect (two-pass)
    // forms, bit 0 marks stores.
    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_STI = 2'b11;

    // Requester indices used by the arbiter request/grant vectors.
    localparam int C_REQ_EX = 0;
    localparam int C_REQ_IF = 1;

    // Sequencer states with a fixed 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ACC  = 3'd2,
        ST_RD   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage : lc3_mem_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter. Grants are combinational and
//                only issued while i_gnt_en is high; the last-grant pointer
//                advances on every issued grant. After reset requester 0
//                has priority.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] i_req,
    input  logic       i_gnt_en,
    output logic [1:0] o_gnt
);

    // Index of the requester granted most recently.
    logic r_last;

    // Grant decode: a lone requester always wins; on contention the one
    // not granted last wins.
    always_comb begin
        o_gnt = 2'b00;
        if (i_gnt_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_last ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // Pointer update; reset value 1 makes requester 0 the first winner.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_ctrl
//  Description : Sequencer/arbiter for the LC-3 data-memory path. Shares the
//                MAR + synchronous DRAM between the fetch and execute units,
//                drives MAR_LE / MAR_CONTROL / WE / Y_OUT, and performs the
//                two-pass indirect accesses (LDI/STI) by reloading MAR from
//                the DRAM output.
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_REQ,
    input  logic [DATA_W-1:0] IF_ADDR,
    output logic              IF_ACK,
    input  logic              EX_REQ,
    input  logic [1:0]        EX_OP,
    input  logic [DATA_W-1:0] EX_ADDR,
    input  logic [DATA_W-1:0] EX_WDATA,
    output logic              EX_ACK,
    output logic [DATA_W-1:0] RDATA,
    input  logic [DATA_W-1:0] MEM_Q,
    output logic              MAR_LE,
    output logic              MAR_CONTROL,
    output logic [DATA_W-1:0] Y_OUT,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              WE,
    output logic              BUSY
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ind;       // first (pointer) pass of LDI/STI pending
    logic              w_ind_nxt;
    logic [1:0]        r_op;        // latched operation (fetch is always LD)
    logic              r_src_if;    // granted requester: 1 = fetch, 0 = execute
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        w_gnt;
    logic              w_gnt_en;
    logic              w_gnt_if;
    logic              w_granted;

    // Requests are only arbitrated while the sequencer is idle.
    assign w_gnt_en  = (r_state == ST_IDLE);
    assign w_gnt_if  = w_gnt[C_REQ_IF];
    assign w_granted = |w_gnt;

    rr_arbiter2 u_arb (
        .CLK      (CLK),
        .RST      (RST),
        .i_req    ({IF_REQ, EX_REQ}),
        .i_gnt_en (w_gnt_en),
        .o_gnt    (w_gnt)
    );

    // State and indirect-phase registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_ind   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ind   <= w_ind_nxt;
        end
    end

    // Capture the granted requester's fields; they stay put until the next
    // grant so a requester dropping REQ mid-access does not disturb it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_src_if <= 1'b0;
            r_op     <= OP_LD;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_granted) begin
            r_src_if <= w_gnt_if;
            r_op     <= w_gnt_if ? OP_LD : EX_OP;
            r_addr   <= w_gnt_if ? IF_ADDR : EX_ADDR;
            r_wdata  <= w_gnt_if ? '0 : EX_WDATA;
        end
    end

    // Read result register: loads at the end of the final RD of a read op.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdata <= '0;
        end else if ((r_state == ST_RD) && !r_ind && !r_op[0]) begin
            r_rdata <= MEM_Q;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ind_nxt   = r_ind;
        MAR_LE      = 1'b0;
        MAR_CONTROL = 1'b0;
        WE          = 1'b0;
        IF_ACK      = 1'b0;
        EX_ACK      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_granted) begin
                    w_ind_nxt   = w_gnt_if ? 1'b0 : EX_OP[1];
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                MAR_LE      = 1'b1;
                w_state_nxt = ST_ACC;
            end
            ST_ACC: begin
                // STI writes only on its second pass, to the pointer address.
                WE          = (r_op == OP_ST) || ((r_op == OP_STI) && !r_ind);
                w_state_nxt = ST_RD;
            end
            ST_RD: begin
                if (r_ind) begin
                    MAR_LE      = 1'b1;
                    MAR_CONTROL = 1'b1;
                    w_ind_nxt   = 1'b0;
                    w_state_nxt = ST_ACC;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                IF_ACK      = r_src_if;
                EX_ACK      = !r_src_if;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign BUSY    = (r_state != ST_IDLE);
    assign Y_OUT   = (r_state == ST_IDLE) ? '0 : r_addr;
    assign WR_DATA = (r_state == ST_IDLE) ? '0 : r_wdata;
    assign RDATA   = r_rdata;

endmodule : lc3_mem_ctrl
`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_mem_ctrl
//  Description : Self-checking bench for lc3_mem_ctrl. Models the MAR and
//                synchronous DRAM of the Data block, and keeps a word-level
//                reference memory plus expected read value for each access.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lc3_mem_ctrl;
    import lc3_mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_REQ, EX_REQ;
    logic [15:0] IF_ADDR, EX_ADDR, EX_WDATA;
    logic [1:0]  EX_OP;
    logic        IF_ACK, EX_ACK;
    logic [15:0] RDATA, MEM_Q, Y_OUT, WR_DATA;
    logic        MAR_LE, MAR_CONTROL, WE, BUSY;

    int checks   = 0;
    int failures = 0;

    lc3_mem_ctrl #(.DATA_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK),
        .EX_REQ(EX_REQ), .EX_OP(EX_OP), .EX_ADDR(EX_ADDR), .EX_WDATA(EX_WDATA),
        .EX_ACK(EX_ACK), .RDATA(RDATA), .MEM_Q(MEM_Q),
        .MAR_LE(MAR_LE), .MAR_CONTROL(MAR_CONTROL), .Y_OUT(Y_OUT),
        .WR_DATA(WR_DATA), .WE(WE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Data block: MAR register in front of a synchronous single-port DRAM
    // decoding address bits [11:0]; a backdoor port preloads contents.
    logic [15:0] mar;
    logic [15:0] dram [0:4095];
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [15:0] bd_data;
    always @(posedge CLK) begin
        if (MAR_LE) mar <= MAR_CONTROL ? MEM_Q : Y_OUT;
        if (WE) dram[mar[11:0]] <= WR_DATA;
        else if (bd_we) dram[bd_addr] <= bd_data;
        MEM_Q <= dram[mar[11:0]];
    end

    // Reference state: what memory holds and what RDATA should show.
    logic [15:0] ref_mem [0:4095];
    logic [15:0] exp_rdata;
    logic [15:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
        @(posedge CLK); #1;
        bd_we = 1'b0;
    endtask

    // One complete access; cycle 0 is the idle cycle in which REQ is first
    // presented. Returns #1 after the edge that ends the ACK cycle.
    task automatic run_acc(input bit is_if, input logic [1:0] op,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input bit drop_early);
        logic [15:0] le_m, ctl_m, we_m, busy_m, y1, rd, ptr, exp_le, exp_ctl, exp_we, exp_busy;
        logic [1:0]  eop;
        logic [11:0] tgt;
        int          ack_at, exp_ack;
        bit          wd_bad, wrong_ack;
        le_m = '0; ctl_m = '0; we_m = '0; busy_m = '0; y1 = '0; rd = '0;
        ack_at = -1; wd_bad = 0; wrong_ack = 0;
        eop = is_if ? OP_LD : op;
        if (is_if) begin
            IF_REQ = 1'b1; IF_ADDR = addr;
        end else begin
            EX_REQ = 1'b1; EX_OP = op; EX_ADDR = addr; EX_WDATA = wdata;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            le_m[k] = MAR_LE; ctl_m[k] = MAR_CONTROL; we_m[k] = WE; busy_m[k] = BUSY;
            if (k == 1) y1 = Y_OUT;
            if (WE && (WR_DATA !== wdata)) wd_bad = 1;
            if ((is_if ? EX_ACK : IF_ACK) === 1'b1) wrong_ack = 1;
            if ((is_if ? IF_ACK : EX_ACK) === 1'b1) begin
                ack_at = k; rd = RDATA;
            end
            @(posedge CLK); #1;
            if (drop_early && k == 1) begin
                IF_REQ = 1'b0; EX_REQ = 1'b0;
            end
            if (ack_at >= 0) break;
        end
        IF_REQ = 1'b0; EX_REQ = 1'b0;

        // Reference behaviour of the access, word level.
        ptr = ref_mem[addr[11:0]];
        tgt = eop[1] ? ptr[11:0] : addr[11:0];
        if (eop[0]) ref_mem[tgt] = wdata;
        else        exp_rdata = ref_mem[tgt];
        exp_ack  = eop[1] ? 6 : 4;
        exp_le   = eop[1] ? 16'b1010 : 16'b0010;
        exp_ctl  = eop[1] ? 16'b1000 : 16'b0000;
        exp_we   = (eop == OP_ST) ? 16'b00100 : (eop == OP_STI) ? 16'b10000 : 16'b0;
        exp_busy = eop[1] ? 16'b1111110 : 16'b11110;

        chk("ack_cycle", ack_at, exp_ack);
        chk("mar_le_cycles", le_m, exp_le);
        chk("mar_ctl_cycles", ctl_m, exp_ctl);
        chk("we_cycles", we_m, exp_we);
        chk("busy_cycles", busy_m, exp_busy);
        chk("y_out_load", y1, addr);
        chk("wr_data_at_we", wd_bad, 0);
        chk("other_ack", wrong_ack, 0);
        chk("rdata_at_ack", rd, exp_rdata);
        if (eop[0]) chk("mem_after_store", dram[tgt], ref_mem[tgt]);
        last_rd = rd;
    endtask

    initial begin : main
        int          ack_who [4];
        int          ack_cyc [4];
        logic [15:0] ack_rd  [4];
        int          n_ack, dbl, late_ack;
        bit          r_if;
        logic [1:0]  r_op;

        RST = 1'b1; IF_REQ = 0; EX_REQ = 0; IF_ADDR = 0; EX_ADDR = 0;
        EX_WDATA = 0; EX_OP = OP_LD; bd_we = 0; bd_addr = 0; bd_data = 0;
        exp_rdata = 16'h0000; last_rd = 16'h0000;

        // Preload the whole DRAM with random words while reset is held.
        @(posedge CLK); #1;
        for (int i = 0; i < 4096; i++) poke(i[11:0], 16'($urandom));

        // Reset state.
        @(negedge CLK);
        chk("reset_busy", BUSY, 0);
        chk("reset_rdata", RDATA, 0);
        chk("reset_ctrl", {MAR_LE, MAR_CONTROL, WE, IF_ACK, EX_ACK}, 0);
        chk("reset_buses", {Y_OUT, WR_DATA}, 0);

        // Both requesters held together from reset: EX first, then alternate.
        @(posedge CLK); #1;
        RST = 1'b0;
        EX_OP = OP_LD; EX_ADDR = 16'h0100; IF_ADDR = 16'h0200;
        EX_REQ = 1'b1; IF_REQ = 1'b1;
        n_ack = 0; dbl = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLK);
            if (IF_ACK && EX_ACK) dbl++;
            if ((IF_ACK || EX_ACK) && n_ack < 4) begin
                ack_who[n_ack] = IF_ACK ? 1 : 0;
                ack_cyc[n_ack] = k;
                ack_rd[n_ack]  = RDATA;
            end
            if (IF_ACK || EX_ACK) n_ack++;
            @(posedge CLK); #1;
            if (n_ack == 4) begin
                EX_REQ = 1'b0; IF_REQ = 1'b0;
            end
        end
        EX_REQ = 1'b0; IF_REQ = 1'b0;
        chk("arb_ack_count", n_ack, 4);
        chk("arb_double_ack", dbl, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < n_ack) begin
                chk("arb_winner", ack_who[i], i % 2);
                chk("arb_ack_cycle", ack_cyc[i], 4 + 5 * i);
                chk("arb_rdata", ack_rd[i], (i % 2) ? ref_mem[12'h200] : ref_mem[12'h100]);
            end
        end
        exp_rdata = ref_mem[12'h200];

        // Directed LD / ST / LDI / STI.
        poke(12'h010, 16'h1234);
        run_acc(0, OP_LD, 16'h0010, 16'h0000, 0);
        chk("ld_0010", last_rd, 16'h1234);
        run_acc(0, OP_ST, 16'h0020, 16'hBEEF, 0);
        run_acc(0, OP_LD, 16'h0020, 16'h0000, 0);
        chk("ld_after_st", last_rd, 16'hBEEF);
        poke(12'h030, 16'h0040);
        poke(12'h040, 16'h5A5A);
        run_acc(0, OP_LDI, 16'h0030, 16'h0000, 0);
        chk("ldi_0030", last_rd, 16'h5A5A);
        run_acc(0, OP_STI, 16'h0030, 16'h0001, 0);
        chk("sti_target", dram[12'h040], 16'h0001);
        chk("sti_pointer_kept", dram[12'h030], 16'h0040);

        // Fetch with upper address bits set, and an EX request dropped early.
        run_acc(1, OP_LD, 16'hF123, 16'h0000, 0);
        run_acc(0, OP_LD, 16'h0456, 16'h0000, 1);

        // Reset during the ACC cycle of a store.
        EX_REQ = 1'b1; EX_OP = OP_ST; EX_ADDR = 16'h0050; EX_WDATA = 16'hC0DE;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_we", {WE, WR_DATA}, {1'b1, 16'hC0DE});
        @(posedge CLK); #1;
        RST = 1'b0; EX_REQ = 1'b0;
        @(negedge CLK);
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_ctrl", {MAR_LE, MAR_CONTROL, WE, IF_ACK, EX_ACK}, 0);
        chk("rst_mid_buses", {Y_OUT, WR_DATA, RDATA}, 0);
        late_ack = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            if (EX_ACK || IF_ACK) late_ack++;
        end
        @(posedge CLK); #1;
        chk("rst_mid_no_ack", late_ack, 0);
        chk("rst_mid_write", dram[12'h050], 16'hC0DE);
        ref_mem[12'h050] = 16'hC0DE;
        exp_rdata = 16'h0000;
        run_acc(0, OP_LD, 16'h0050, 16'h0000, 0);
        chk("ld_after_rst", last_rd, 16'hC0DE);

        // Randomized mix of fetches and all four execute ops.
        for (int n = 0; n < 40; n++) begin
            r_if = ($urandom_range(0, 3) == 0);
            r_op = 2'($urandom_range(0, 3));
            run_acc(r_if, r_op, 16'($urandom), 16'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lc3_mem_ctrl
`default_nettype wire
